nids_match_engine: RTL and testbench
====================================

Name: nids_match_engine

Overview:
- Traversal controller that acts as the initiator on the transition-memory lookup interface.
- Accepts a packet byte stream and computes each lookup address from the current state and the incoming character.
- Drives the lookup request, captures the registered response {final flag, next state, 32-bit path vector}, and keeps a running AND of path vectors.
- Emits a one-cycle match report when a final state is reached with a non-zero vector. Sits between the packet byte parser and the alert/report logic.

Parameters:
- STATE_W, 8, width of the state field used from the lookup response.
- ADDR_W, 10, lookup address width.
- VEC_W, 32, path vector width (one bit per rule).
- POS_W, 16, byte position counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- char_in  in  8  packet byte
- char_valid  in  1  char_in valid
- char_last  in  1  qualifies char_in as the final byte of a packet
- char_ready  out  1  engine can accept a byte this cycle
- data_in  out  ADDR_W  lookup address to the memory
- n_valid  out  1  active-high "no request"; 0 means a lookup is issued
- valid_state  in  ADDR_W  next state from the memory; low STATE_W bits used
- pathVec  in  VEC_W  path vector from the memory
- ifFinal  in  1  final-state flag from the memory
- match_valid  out  1  one-cycle match pulse
- match_vec  out  VEC_W  rules matched
- match_pos  out  POS_W  0-based byte index of the matching byte
- match_cnt  out  16  saturating match count (see Optional Feature)

Behaviour:
- Reset values:
  - char_ready=0, data_in=0, n_valid=1.
  - match_valid=0, match_vec=0, match_pos=0, match_cnt=0.
  - Internal: cur_state=0, run_vec=all-ones, pos=0, FSM=IDLE.
  - char_ready rises in the first cycle after reset deasserts.
  - Reset mid-lookup abandons the lookup; no match is reported.
- FSM IDLE:
  - char_ready=1, n_valid=1.
  - On char_valid: latch char_in and char_last.
  - Register data_in = (zero-extended cur_state + char_in) mod 2^ADDR_W.
  - Set n_valid=0. Go to ISSUE.
- FSM ISSUE:
  - char_ready=0. data_in and n_valid=0 are held for exactly this one cycle, so the memory registers its response at the end of this cycle.
  - Next cycle n_valid=1. Go to CAPTURE.
- FSM CAPTURE:
  - Sample valid_state, pathVec, ifFinal (memory latency 1). Compute nv = run_vec & pathVec.
  - Miss (pathVec all-ones and ifFinal=0) or nv==0: cur_state<=0, run_vec<=all-ones.
  - Otherwise: cur_state<=valid_state[STATE_W-1:0], run_vec<=nv.
  - ifFinal=1 and nv!=0: next cycle match_valid=1, match_vec=nv, match_pos=pos. Then cur_state<=0, run_vec<=all-ones (restart at root).
  - pos<=pos+1, saturating at all-ones.
  - If latched last=1: cur_state<=0, run_vec<=all-ones, pos<=0, overriding the updates above. A match on the last byte is still reported with the pre-clear pos.
  - Go to IDLE.
- Throughput: one byte per 3 cycles (IDLE accept, ISSUE, CAPTURE). Match pulse appears 3 cycles after byte acceptance.
- match_vec and match_pos hold their values between pulses. match_valid is never asserted for two consecutive cycles.
- char_valid while char_ready=0 is ignored; the upstream stage must hold the byte until the handshake.

Optional Feature:
- NIDS_MATCH_COUNT_EN.
- Defined: match_cnt increments on every match_valid pulse and saturates at 0xFFFF. It is cleared only by reset, not by char_last.
- Undefined: match_cnt is tied to 0 and the counter logic is absent.

Test Plan:
- Reset held 2 cycles, then released → all outputs at reset values; char_ready=1 on the first post-reset cycle; n_valid=1 throughout.
- Bytes 0x03,0x01,0x01,0x01,0x01 from root against the standard table → data_in sequence 3,4,5,6,7. Sixth byte 0x01 gives addr 8 (final, vec 0x00000209) → match_valid=1, match_vec=0x00000209, match_pos=5, exactly 3 cycles after the sixth accept.
- Byte 0x00 from root → addr 0 returns pathVec all-ones with ifFinal=0 → cur_state stays 0, no match; next byte 0x05 → data_in=5.
- Match sequence of the second test with char_last on the sixth byte → match reported with pos 5; next byte 0x03 → data_in=3, and a later match reports pos counted from 0.
- Reset asserted during ISSUE → no match_valid; n_valid=1 the next cycle; state returns to root.
- With NIDS_MATCH_COUNT_EN: two complete match sequences → match_cnt=2. Without the macro: match_cnt=0 after the same stimulus.

Source files
------------

// File: rtl/nids_match_engine.sv
// NIDS traversal controller: walks the transition memory one byte per three cycles
// and reports final states reached with a non-zero running path vector. Optional NIDS_MATCH_COUNT_EN.
module nids_match_engine #(
   parameter int unsigned STATE_W = 8,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned VEC_W   = 32,
   parameter int unsigned POS_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        char_in,
   input  logic              char_valid,
   input  logic              char_last,
   output logic              char_ready,
   output logic [ADDR_W-1:0] data_in,
   output logic              n_valid,
   input  logic [ADDR_W-1:0] valid_state,
   input  logic [VEC_W-1:0]  pathVec,
   input  logic              ifFinal,
   output logic              match_valid,
   output logic [VEC_W-1:0]  match_vec,
   output logic [POS_W-1:0]  match_pos,
   output logic [15:0]       match_cnt
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t               state, state_nxt;
   logic                 accept;
   logic [STATE_W-1:0]   cur_state;
   logic [VEC_W-1:0]     run_vec;
   logic [POS_W-1:0]     pos;
   logic [POS_W-1:0]     pos_inc;
   logic                 last_q;
   logic [ADDR_W-1:0]    lookup_addr;
   logic [VEC_W-1:0]     nv;
   logic                 miss;
   logic                 hit_final;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (char_ready && char_valid) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      lookup_addr = ADDR_W'(cur_state) + ADDR_W'(char_in);
      nv          = run_vec & pathVec;
      miss        = (pathVec == '1) && !ifFinal;
      hit_final   = ifFinal && (nv != '0);
      pos_inc     = (pos == '1) ? pos : pos + POS_W'(1);
   end

   // char_ready is registered so it stays low through reset and rises one cycle after release.
   always_ff @(posedge clk) begin
      if (reset) begin
         char_ready  <= 1'b0;
         data_in     <= '0;
         n_valid     <= 1'b1;
         match_valid <= 1'b0;
         match_vec   <= '0;
         match_pos   <= '0;
         cur_state   <= '0;
         run_vec     <= '1;
         pos         <= '0;
         last_q      <= 1'b0;
      end else begin
         char_ready  <= (state_nxt == IDLE);
         match_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  data_in <= lookup_addr;
                  n_valid <= 1'b0;
                  last_q  <= char_last;
               end
            end
            ISSUE: n_valid <= 1'b1;
            CAPTURE: begin
               if (hit_final) begin
                  match_valid <= 1'b1;
                  match_vec   <= nv;
                  match_pos   <= pos;
               end
               // A match, a miss, an empty vector or end of packet all restart at the root.
               if (last_q || hit_final || miss || (nv == '0)) begin
                  cur_state <= '0;
                  run_vec   <= '1;
               end else begin
                  cur_state <= valid_state[STATE_W-1:0];
                  run_vec   <= nv;
               end
               pos <= last_q ? '0 : pos_inc;
            end
            default: ;
         endcase
      end
   end

   generate
      if (ADDR_W > STATE_W) begin : g_unused_state
         logic unused_state_bits;
         assign unused_state_bits = ^valid_state[ADDR_W-1:STATE_W];
      end
   endgenerate

`ifdef NIDS_MATCH_COUNT_EN
   logic [15:0] cnt;
   // Counted on the same edge that raises match_valid so the count includes the current pulse.
   always_ff @(posedge clk) begin
      if (reset)                                       cnt <= '0;
      else if ((state == CAPTURE) && hit_final && (cnt != '1)) cnt <= cnt + 16'd1;
   end
   assign match_cnt = cnt;
`else
   assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_nids_match_engine.sv
// Directed bench for nids_match_engine with a transaction-level model and per-cycle compare.
module tb_nids_match_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  char_in = '0;
   logic        char_valid = 1'b0;
   logic        char_last = 1'b0;
   logic        char_ready;
   logic [9:0]  data_in;
   logic        n_valid;
   logic [9:0]  valid_state = '0;
   logic [31:0] pathVec = '0;
   logic        ifFinal = 1'b0;
   logic        match_valid;
   logic [31:0] match_vec;
   logic [15:0] match_pos;
   logic [15:0] match_cnt;

   always #5 clk = ~clk;

   nids_match_engine #(.STATE_W(8), .ADDR_W(10), .VEC_W(32), .POS_W(16)) dut (
      .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
      .char_last(char_last), .char_ready(char_ready), .data_in(data_in),
      .n_valid(n_valid), .valid_state(valid_state), .pathVec(pathVec),
      .ifFinal(ifFinal), .match_valid(match_valid), .match_vec(match_vec),
      .match_pos(match_pos), .match_cnt(match_cnt)
   );

   logic [9:0]  t_state [0:1023];
   logic [31:0] t_vec   [0:1023];
   logic        t_fin   [0:1023];

   always @(posedge clk) begin
      if (!n_valid) begin
         valid_state <= t_state[data_in];
         pathVec     <= t_vec[data_in];
         ifFinal     <= t_fin[data_in];
      end
   end

   int          n_vec = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;
   logic        e_ready, e_nvalid, e_mvalid;
   logic [9:0]  e_addr;
   logic [31:0] e_mvec;
   logic [15:0] e_mpos, e_cnt;
   logic [9:0]  seen_addr = '0;

   int          m_cur, m_pos, m_cnt;
   logic [31:0] m_run;
   bit          pend;
   logic [31:0] pend_vec;
   logic [15:0] pend_pos, pend_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("char_ready", 32'(char_ready), 32'(e_ready));
         chk("n_valid", 32'(n_valid), 32'(e_nvalid));
         chk("data_in", 32'(data_in), 32'(e_addr));
         chk("match_valid", 32'(match_valid), 32'(e_mvalid));
         chk("match_vec", match_vec, e_mvec);
         chk("match_pos", 32'(match_pos), 32'(e_mpos));
         chk("match_cnt", 32'(match_cnt), 32'(e_cnt));
         if (!n_valid) seen_addr = data_in;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      m_cur = 0; m_run = '1; m_pos = 0; m_cnt = 0; pend = 1'b0;
      e_ready = 1'b0; e_nvalid = 1'b1; e_addr = '0; e_mvalid = 1'b0;
      e_mvec = '0; e_mpos = '0; e_cnt = '0;
   endtask

   task automatic do_reset;
      chk_en = 1'b0; reset = 1'b1; char_valid = 1'b0; char_last = 1'b0;
      tick;
      model_reset;
      chk_en = 1'b1;
      tick;
      reset = 1'b0;
      tick;
      e_ready = 1'b1;
   endtask

   task automatic set_idle_exp;
      e_ready = 1'b1; e_nvalid = 1'b1;
      if (pend) begin
         e_mvalid = 1'b1; e_mvec = pend_vec; e_mpos = pend_pos; e_cnt = pend_cnt;
         pend = 1'b0;
      end else begin
         e_mvalid = 1'b0;
      end
   endtask

   task automatic idle;
      set_idle_exp;
      char_valid = 1'b0;
      tick;
   endtask

   task automatic send(input logic [7:0] c, input bit last, input bit abort);
      int addr;
      logic [31:0] v, nv;
      logic fin;
      set_idle_exp;
      char_in = c; char_last = last; char_valid = 1'b1;
      tick;
      addr = (m_cur + int'(c)) % 1024;
      e_ready = 1'b0; e_nvalid = 1'b0; e_addr = 10'(addr); e_mvalid = 1'b0;
      char_in = 8'hEE; char_last = 1'b1; char_valid = 1'b1;
      if (abort) begin
         @(negedge clk);
         #1;
         reset = 1'b1; char_valid = 1'b0; char_last = 1'b0;
         tick;
         model_reset;
         reset = 1'b0;
         tick;
         e_ready = 1'b1;
         return;
      end
      tick;
      e_nvalid = 1'b1; char_valid = 1'b0; char_last = 1'b0;
      tick;
      v = t_vec[addr]; fin = t_fin[addr]; nv = m_run & v;
      if (fin && nv != 0) begin
         if (m_cnt < 65535) m_cnt++;
         pend = 1'b1; pend_vec = nv; pend_pos = 16'(m_pos);
`ifdef NIDS_MATCH_COUNT_EN
         pend_cnt = 16'(m_cnt);
`else
         pend_cnt = 16'd0;
`endif
         m_cur = 0; m_run = '1;
      end else if ((v == '1 && !fin) || nv == 0) begin
         m_cur = 0; m_run = '1;
      end else begin
         m_cur = int'(t_state[addr]) % 256; m_run = nv;
      end
      if (m_pos < 65535) m_pos++;
      if (last) begin m_pos = 0; m_cur = 0; m_run = '1; end
   endtask

   task automatic match_seq(input bit last_on_sixth);
      send(8'h03, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send(8'h01, 1'b0, 1'b0);
      send(8'h01, last_on_sixth, 1'b0);
      idle;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int a = 0; a < 1024; a++) begin
         t_state[a] = '0; t_vec[a] = '1; t_fin[a] = 1'b0;
      end
      t_state[3] = 10'd3;   t_vec[3] = 32'h0000_FFFF;
      t_state[4] = 10'd4;   t_vec[4] = 32'h00FF_0F0F;
      t_state[5] = 10'd5;   t_vec[5] = 32'hFFFF_0209;
      t_state[6] = 10'd6;   t_vec[6] = 32'h0F0F_0F0F;
      t_state[7] = 10'h307; t_vec[7] = 32'h0000_0FFF;
      t_state[8] = 10'h02A; t_vec[8] = 32'h0000_0209; t_fin[8] = 1'b1;
      t_state[9] = 10'd0;   t_vec[9] = 32'h0001_0000; t_fin[9] = 1'b1;

      do_reset;
      idle; idle;

      // standard walk: addresses 3..8 and a match at byte 5
      send(8'h03, 1'b0, 1'b0); chk("lit_addr0", 32'(seen_addr), 32'd3);
      for (int i = 0; i < 4; i++) begin
         send(8'h01, 1'b0, 1'b0);
         chk("lit_addr", 32'(seen_addr), 32'(4 + i));
      end
      send(8'h01, 1'b0, 1'b0); chk("lit_addr5", 32'(seen_addr), 32'd8);
      idle;
      chk("lit_vec", match_vec, 32'h0000_0209);
      chk("lit_pos", 32'(match_pos), 32'd5);

      // miss from root, then root-relative address
      send(8'h00, 1'b0, 1'b0); chk("lit_miss_addr", 32'(seen_addr), 32'd0);
      send(8'h05, 1'b0, 1'b0); chk("lit_after_miss", 32'(seen_addr), 32'd5);
      send(8'h00, 1'b1, 1'b0);

      // match on the last byte, then positions restart from zero
      match_seq(1'b1);
      chk("lit_last_pos", 32'(match_pos), 32'd5);
      send(8'h03, 1'b0, 1'b0); chk("lit_after_last", 32'(seen_addr), 32'd3);
      for (int i = 0; i < 5; i++) send(8'h01, 1'b0, 1'b0);
      idle;
      chk("lit_pos_restart", 32'(match_pos), 32'd5);
`ifdef NIDS_MATCH_COUNT_EN
      chk("lit_cnt3", 32'(match_cnt), 32'd3);
`else
      chk("lit_cnt3", 32'(match_cnt), 32'd0);
`endif

      // final state with empty running vector: no match, back to root
      send(8'h03, 1'b0, 1'b0);
      send(8'h06, 1'b0, 1'b0); chk("lit_addr9", 32'(seen_addr), 32'd9);
      idle;
      send(8'h05, 1'b0, 1'b0); chk("lit_nv0_root", 32'(seen_addr), 32'd5);

      // reset during ISSUE of a matching byte
      send(8'h00, 1'b1, 1'b0);
      send(8'h03, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send(8'h01, 1'b0, 1'b0);
      send(8'h01, 1'b0, 1'b1);
      idle; idle;
      send(8'h05, 1'b0, 1'b0); chk("lit_reset_root", 32'(seen_addr), 32'd5);
      idle; idle;

      // two complete matches after reset
      send(8'h00, 1'b1, 1'b0);
      match_seq(1'b0);
      match_seq(1'b0);
      idle;
`ifdef NIDS_MATCH_COUNT_EN
      chk("lit_cnt2", 32'(match_cnt), 32'd2);
`else
      chk("lit_cnt2", 32'(match_cnt), 32'd0);
`endif

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
